// File: rtl/fft16_ctrl.sv
// fft16_ctrl: sequencing controller for an in-place 16-point radix-4 FFT.
// Loads 16 samples, runs 2 stages x 4 butterflies through an external
// butterfly pipeline of BF_LAT cycles, then unloads bins in digit-reversed
// memory order (bin k = 4*k1+k0 lives at address 4*k0+k1).
module fft16_ctrl #(
    parameter int BF_LAT = 2            // butterfly latency, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ld_we,
    output logic [3:0] ld_addr,
    output logic       stage,
    output logic [1:0] butterfly,
    output logic       rd_en,
    output logic       wr_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_addr,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_UNLOAD
    } state_e;

    // WAIT lasts BF_LAT cycles: the counter is loaded in READ and WAIT exits at zero.
    localparam logic [3:0] WAIT_INIT = 4'(BF_LAT - 1);

    state_e     r_state;
    state_e     w_next;
    logic [3:0] r_ld_addr;
    logic [3:0] r_wait_cnt;
    logic [3:0] r_k;          // output counter, natural bin order
    logic       r_stage;
    logic [1:0] r_bfly;
    logic       r_done;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   if (in_valid && r_ld_addr == 4'd15) w_next = S_READ;
            S_READ:   w_next = S_WAIT;
            S_WAIT:   if (r_wait_cnt == 4'd0) w_next = S_WRITE;
            S_WRITE:  w_next = (r_stage && r_bfly == 2'd3) ? S_UNLOAD : S_READ;
            S_UNLOAD: if (out_ready && r_k == 4'd15) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Counters: load index, latency down-counter, stage/butterfly, output index, done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_addr  <= '0;
            r_wait_cnt <= '0;
            r_k        <= '0;
            r_stage    <= 1'b0;
            r_bfly     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ld_addr <= '0;
                        r_k       <= '0;
                    end
                end
                S_LOAD: begin
                    // 4-bit counter wraps to 0 on the 16th accepted sample.
                    if (in_valid) r_ld_addr <= r_ld_addr + 4'd1;
                end
                S_READ: begin
                    r_wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                S_WRITE: begin
                    // Last butterfly of stage 1 wraps both fields back to 0 for UNLOAD.
                    if (r_bfly == 2'd3) begin
                        r_bfly  <= 2'd0;
                        r_stage <= ~r_stage;
                    end else begin
                        r_bfly <= r_bfly + 2'd1;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        r_k <= r_k + 4'd1;
                        if (r_k == 4'd15) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the current state and counters.
    always_comb begin
        busy      = (r_state != S_IDLE);
        in_ready  = (r_state == S_LOAD);
        ld_we     = in_valid && (r_state == S_LOAD);
        rd_en     = (r_state == S_READ);
        wr_en     = (r_state == S_WRITE);
        out_valid = (r_state == S_UNLOAD);
        ld_addr   = r_ld_addr;
        stage     = r_stage;
        butterfly = r_bfly;
        // Digit reversal: k = 4*k1 + k0 maps to address 4*k0 + k1.
        out_addr  = {r_k[1:0], r_k[3:2]};
        done      = r_done;
    end

endmodule
